ddr3_traffic_checker: RTL and testbench
=======================================

Name: ddr3_traffic_checker

Overview:
- Parametrised loopback traffic generator/checker driving the user port of ddr3_memory_controller; successor of the fixed incrementing loopback test top.
- Writes NUM_OF_TRANSFERS words over a contiguous address window, then reads them back and compares against a regenerated pattern.
- Supports four selectable data patterns, a ready/valid command handshake and pipelined reads with bounded outstanding requests.
- Reports pass/fail, a saturating error count and details of the first mismatch for ILA capture or LEDs.

Parameters:
ADDRESS_BITWIDTH, 15, DDR row/column address width
BANK_ADDRESS_BITWIDTH, 3, bank address width
DQ_BITWIDTH, 16, user data width (>=4)
NUM_OF_TRANSFERS, 256, words per write phase and per read phase (>=1)
START_ADDRESS, 0, first user address of the test window
MAX_OUTSTANDING_READS, 4, read commands accepted but not yet answered (1..15)
LFSR_TAPS, 16'hB400, Galois feedback mask, low DQ_BITWIDTH bits used
LFSR_SEED, 16'hACE1, nonzero LFSR start value, low DQ_BITWIDTH bits used

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a run when not busy
mode  in  2  pattern: 0 incrementing, 1 inverted index, 2 walking one, 3 LFSR
write_enable  out  1  write command request
read_enable  out  1  read command request
i_user_data_address  out  BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH  command address
i_user_data  out  DQ_BITWIDTH  write data
cmd_ready  in  1  controller accepts the presented command this cycle
o_user_data  in  DQ_BITWIDTH  read return data
o_user_data_valid  in  1  o_user_data valid this cycle; returns are in order
busy  out  1  run in progress
done  out  1  run finished; held until next accepted start
pass  out  1  done and error_count == 0
error_count  out  16  saturating mismatch count
first_error_address  out  BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH  address of first mismatch
first_error_data  out  DQ_BITWIDTH  data received at first mismatch

Behaviour:
- Reset, asynchronous: state IDLE; all outputs and counters 0; mode latch 0; LFSRs = LFSR_SEED.
- States: IDLE -> WRITE -> READ -> DRAIN -> DONE. Start is accepted in IDLE or DONE.
- Accepting start latches mode, clears done, pass, error_count and first_error_*, reloads both LFSRs, sets busy and enters WRITE on the next cycle. start while busy is ignored.
- Pattern for index k: mode 0 gives k; mode 1 gives ~k; mode 2 gives 1<<(k mod DQ_BITWIDTH); mode 3 gives the LFSR state, stepped once per consumed word. All values are truncated to DQ_BITWIDTH.
- Address = START_ADDRESS + k, wrapping modulo 2^(BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH).
- Handshake: a request is held with address and data stable until the cycle cmd_ready=1. That cycle is the acceptance, and the next index is presented the following cycle with no bubble.
- WRITE: write_enable=1 for k = 0..NUM_OF_TRANSFERS-1. After the last acceptance, go to READ with k reset to 0.
- READ: read_enable=1 only while outstanding < MAX_OUTSTANDING_READS. After the last read acceptance, go to DRAIN.
- Outstanding counter: +1 on read acceptance, -1 on o_user_data_valid, unchanged when both occur in the same cycle.
- Checker: on each o_user_data_valid with outstanding > 0, compare against the expected pattern for index j, then j+1.
  - On mismatch: error_count increments, saturating at 16'hFFFF.
  - On the first mismatch only: capture that address and the received data.
- o_user_data_valid while outstanding == 0 counts as one error and does not advance j.
- DRAIN -> DONE once j == NUM_OF_TRANSFERS. DONE: busy=0, done=1, pass=(error_count==0), all enables 0.
- Latency: start to first write_enable is 1 cycle. The final valid return raises done on the next cycle.

Optional Feature:
- Macro ERROR_INJECT_EN.
- When defined:
  - Adds input inject_error (1), sampled at start acceptance.
  - If that sample is 1, the write data for index 0 has bit 0 inverted, so the run must end with error_count=1 and pass=0.
- When undefined: no port, write data is always the unmodified pattern.

Test Plan:
- Ideal memory model (cmd_ready=1, read latency 3), mode 0, NUM_OF_TRANSFERS=256 -> 256 writes of data 0..255 at addresses 0..255, 256 reads, done=1, pass=1, error_count=0.
- Mode 2, DQ_BITWIDTH=16, cmd_ready toggling 1/0 -> index 17 written as 16'h0002; address/data stable across stalls; pass=1.
- Read latency 20, MAX_OUTSTANDING_READS=4 -> outstanding never exceeds 4; read_enable drops at 4 outstanding; all 256 checked; pass=1.
- Model corrupts the readback at address 5 to 16'h0000 and at address 9, mode 0 -> error_count=2, first_error_address=5, first_error_data=16'h0000, pass=0.
- reset asserted mid-READ, then start -> all outputs 0 immediately on reset; the new run starts a fresh write at address START_ADDRESS and passes.
- Spurious o_user_data_valid in IDLE, then a normal run; ERROR_INJECT_EN with inject_error=1 -> first case: error_count=1 is cleared by start. Second case: error_count=1, first_error_address=0.

Source files
------------

// File: rtl/ddr3_traffic_checker.sv
// Loopback traffic generator/checker for the ddr3_memory_controller user port.
// Latency: first write command one cycle after start; done one cycle after the final read return.
// Backpressure: commands hold address/data until cmd_ready; reads also throttle on outstanding count.
// Optional feature macro: ERROR_INJECT_EN (adds inject_error, flips bit 0 of word 0).
module ddr3_traffic_checker #(
    parameter int          ADDRESS_BITWIDTH      = 15,
    parameter int          BANK_ADDRESS_BITWIDTH = 3,
    parameter int          DQ_BITWIDTH           = 16,
    parameter int          NUM_OF_TRANSFERS      = 256,
    parameter int          START_ADDRESS         = 0,
    parameter int          MAX_OUTSTANDING_READS = 4,
    parameter logic [15:0] LFSR_TAPS             = 16'hB400,
    parameter logic [15:0] LFSR_SEED             = 16'hACE1
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              start,
    input  logic [1:0]                                        mode,
`ifdef ERROR_INJECT_EN
    input  logic                                              inject_error,
`endif
    output logic                                              write_enable,
    output logic                                              read_enable,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
    output logic [DQ_BITWIDTH-1:0]                            i_user_data,
    input  logic                                              cmd_ready,
    input  logic [DQ_BITWIDTH-1:0]                            o_user_data,
    input  logic                                              o_user_data_valid,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              pass,
    output logic [15:0]                                       error_count,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address,
    output logic [DQ_BITWIDTH-1:0]                            first_error_data
);

    localparam int               AW   = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
    localparam logic [31:0]      NT   = 32'(NUM_OF_TRANSFERS);
    localparam logic [3:0]       MAXO = 4'(MAX_OUTSTANDING_READS);
    localparam logic [DQ_BITWIDTH-1:0] TAPS = DQ_BITWIDTH'(LFSR_TAPS);
    localparam logic [DQ_BITWIDTH-1:0] SEED = DQ_BITWIDTH'(LFSR_SEED);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                 state;
    logic [1:0]             mode_q;
    logic [31:0]            cmd_idx;      // generator index k (writes, then reads)
    logic [31:0]            chk_idx;      // checker index j
    logic [3:0]             outstanding;
    logic [DQ_BITWIDTH-1:0] gen_lfsr;
    logic [DQ_BITWIDTH-1:0] chk_lfsr;
    logic                   first_seen;

    // Galois LFSR, shifting right with feedback from bit 0
    function automatic logic [DQ_BITWIDTH-1:0] lfsr_step(input logic [DQ_BITWIDTH-1:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    function automatic logic [DQ_BITWIDTH-1:0] pattern(input logic [1:0] m,
                                                       input logic [31:0] idx,
                                                       input logic [DQ_BITWIDTH-1:0] lf);
        logic [DQ_BITWIDTH-1:0] r;
        case (m)
            2'd0:    r = DQ_BITWIDTH'(idx);
            2'd1:    r = ~DQ_BITWIDTH'(idx);
            2'd2:    r = DQ_BITWIDTH'(1) << (idx % DQ_BITWIDTH);
            default: r = lf;
        endcase
        return r;
    endfunction

    function automatic logic [AW-1:0] word_address(input logic [31:0] idx);
        return AW'(32'(START_ADDRESS) + idx);
    endfunction

    // Injection only ever touches bit 0 of word 0
    function automatic logic [DQ_BITWIDTH-1:0] write_word(input logic [1:0] m,
                                                          input logic [31:0] idx,
                                                          input logic [DQ_BITWIDTH-1:0] lf,
                                                          input logic inj);
        return pattern(m, idx, lf) ^ DQ_BITWIDTH'(inj && (idx == 32'd0));
    endfunction

    logic inj_start;
    logic inj_run;

`ifdef ERROR_INJECT_EN
    logic inject_q;

    // Remember the injection request of the run that is starting
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            inject_q <= 1'b0;
        else if (start && (state == IDLE || state == DONE))
            inject_q <= inject_error;
    end

    assign inj_start = inject_error;
    assign inj_run   = inject_q;
`else
    assign inj_start = 1'b0;
    assign inj_run   = 1'b0;
`endif

    logic                   wr_acc;
    logic                   rd_acc;
    logic                   ret_ok;
    logic                   spurious;
    logic                   mismatch;
    logic [DQ_BITWIDTH-1:0] exp_data;
    logic [15:0]            err_nxt;
    logic [3:0]             out_nxt;
    logic [31:0]            chk_idx_nxt;
    logic [31:0]            cmd_idx_inc;
    logic [DQ_BITWIDTH-1:0] gen_lfsr_nxt;

    // Handshake decode, return checking and next-value arithmetic
    always_comb begin
        wr_acc       = write_enable & cmd_ready;
        rd_acc       = read_enable & cmd_ready;
        ret_ok       = o_user_data_valid & (outstanding != 4'd0);
        spurious     = o_user_data_valid & (outstanding == 4'd0);
        exp_data     = pattern(mode_q, chk_idx, chk_lfsr);
        mismatch     = ret_ok & (o_user_data != exp_data);
        err_nxt      = error_count;
        if ((mismatch || spurious) && (error_count != 16'hFFFF))
            err_nxt = error_count + 16'd1;
        out_nxt      = outstanding;
        if (rd_acc && !ret_ok)
            out_nxt = outstanding + 4'd1;
        else if (!rd_acc && ret_ok)
            out_nxt = outstanding - 4'd1;
        chk_idx_nxt  = chk_idx + (ret_ok ? 32'd1 : 32'd0);
        cmd_idx_inc  = cmd_idx + 32'd1;
        gen_lfsr_nxt = lfsr_step(gen_lfsr);
    end

    // Run sequencer, command generator and readback checker
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            mode_q              <= 2'd0;
            cmd_idx             <= 32'd0;
            chk_idx             <= 32'd0;
            outstanding         <= 4'd0;
            gen_lfsr            <= SEED;
            chk_lfsr            <= SEED;
            first_seen          <= 1'b0;
            write_enable        <= 1'b0;
            read_enable         <= 1'b0;
            i_user_data_address <= '0;
            i_user_data         <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            pass                <= 1'b0;
            error_count         <= 16'd0;
            first_error_address <= '0;
            first_error_data    <= '0;
        end else begin
            // The checker runs in every state so stray returns are always counted
            error_count <= err_nxt;
            outstanding <= out_nxt;
            chk_idx     <= chk_idx_nxt;
            if (ret_ok)
                chk_lfsr <= lfsr_step(chk_lfsr);
            if (mismatch && !first_seen) begin
                first_seen          <= 1'b1;
                first_error_address <= word_address(chk_idx);
                first_error_data    <= o_user_data;
            end

            case (state)
                IDLE, DONE: begin
                    if (state == DONE)
                        pass <= (err_nxt == 16'd0);
                    if (start) begin
                        state               <= WRITE;
                        mode_q              <= mode;
                        busy                <= 1'b1;
                        done                <= 1'b0;
                        pass                <= 1'b0;
                        error_count         <= 16'd0;
                        first_seen          <= 1'b0;
                        first_error_address <= '0;
                        first_error_data    <= '0;
                        gen_lfsr            <= SEED;
                        chk_lfsr            <= SEED;
                        cmd_idx             <= 32'd0;
                        chk_idx             <= 32'd0;
                        write_enable        <= 1'b1;
                        i_user_data_address <= word_address(32'd0);
                        i_user_data         <= write_word(mode, 32'd0, SEED, inj_start);
                    end
                end

                WRITE: begin
                    if (wr_acc) begin
                        gen_lfsr <= gen_lfsr_nxt;
                        if (cmd_idx == NT - 32'd1) begin
                            state               <= READ;
                            write_enable        <= 1'b0;
                            read_enable         <= 1'b1;
                            cmd_idx             <= 32'd0;
                            i_user_data_address <= word_address(32'd0);
                            i_user_data         <= '0;
                        end else begin
                            cmd_idx             <= cmd_idx_inc;
                            i_user_data_address <= word_address(cmd_idx_inc);
                            i_user_data         <= write_word(mode_q, cmd_idx_inc, gen_lfsr_nxt, inj_run);
                        end
                    end
                end

                READ: begin
                    read_enable <= (out_nxt < MAXO);
                    if (rd_acc) begin
                        if (cmd_idx == NT - 32'd1) begin
                            state       <= DRAIN;
                            read_enable <= 1'b0;
                        end else begin
                            cmd_idx             <= cmd_idx_inc;
                            i_user_data_address <= word_address(cmd_idx_inc);
                        end
                    end
                end

                DRAIN: begin
                    if (chk_idx_nxt == NT) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt == 16'd0);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_traffic_checker.sv
// Scoreboard bench for ddr3_traffic_checker with a simple in-order memory model.
// Stimulus pushes expected commands/results; a monitor pops them as the DUT issues them.
module tb_ddr3_traffic_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic        write_enable;
    logic        read_enable;
    logic [17:0] i_user_data_address;
    logic [15:0] i_user_data;
    logic        cmd_ready;
    logic [15:0] o_user_data;
    logic        o_user_data_valid;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] error_count;
    logic [17:0] first_error_address;
    logic [15:0] first_error_data;
`ifdef ERROR_INJECT_EN
    logic        inject_error;
`endif

    ddr3_traffic_checker dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .mode                (mode),
`ifdef ERROR_INJECT_EN
        .inject_error        (inject_error),
`endif
        .write_enable        (write_enable),
        .read_enable         (read_enable),
        .i_user_data_address (i_user_data_address),
        .i_user_data         (i_user_data),
        .cmd_ready           (cmd_ready),
        .o_user_data         (o_user_data),
        .o_user_data_valid   (o_user_data_valid),
        .busy                (busy),
        .done                (done),
        .pass                (pass),
        .error_count         (error_count),
        .first_error_address (first_error_address),
        .first_error_data    (first_error_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct { int due; logic [15:0] d; } ret_t;
    ret_t        rq[$];
    logic [15:0] mem [logic [17:0]];
    int  cyc = 0;
    int  lat = 3;
    bit  stall = 0;
    bit  corrupt = 0;
    bit  spur_req = 0;
    int  out_m = 0;
    int  out_cur = 0;
    int  max_out = 0;
    int  last_ret_cyc = 0;
    int  rd_returned = 0;
    int  rd_accepted = 0;

    initial begin
        cmd_ready = 1'b0;
        o_user_data = 16'h0;
        o_user_data_valid = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            out_cur = out_m;
            o_user_data_valid = 1'b0;
            o_user_data = 16'h0;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                o_user_data_valid = 1'b1;
                o_user_data = rq[0].d;
                void'(rq.pop_front());
                out_m--;
                rd_returned++;
                last_ret_cyc = cyc;
            end else if (spur_req) begin
                o_user_data_valid = 1'b1;
                o_user_data = 16'h1234;
                spur_req = 0;
            end
            cmd_ready = stall ? ((cyc % 2) == 0) : 1'b1;
            if (write_enable && cmd_ready)
                mem[i_user_data_address] = i_user_data;
            if (read_enable && cmd_ready) begin
                logic [15:0] d;
                d = mem.exists(i_user_data_address) ? mem[i_user_data_address] : 16'hXXXX;
                if (corrupt && i_user_data_address == 18'd5) d = 16'h0000;
                if (corrupt && i_user_data_address == 18'd9) d = 16'hBEEF;
                rq.push_back('{cyc + lat, d});
                out_m++;
                rd_accepted++;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic [17:0] a; logic [15:0] d; } wr_t;
    typedef struct { logic [15:0] ec; logic p; logic [17:0] fa; logic [15:0] fd; } res_t;
    wr_t         exp_wr[$];
    logic [17:0] exp_rd[$];
    res_t        exp_res[$];

    bit          hold_w = 0, hold_r = 0, done_q = 0;
    logic [17:0] hw_a, hr_a;
    logic [15:0] hw_d;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                hold_w = 0; hold_r = 0; done_q = 0;
            end else begin
                if (hold_w) begin
                    cmp("wr_hold_en", 32'(write_enable), 32'd1);
                    cmp("wr_hold_addr", 32'(i_user_data_address), 32'(hw_a));
                    cmp("wr_hold_data", 32'(i_user_data), 32'(hw_d));
                end
                if (hold_r) begin
                    cmp("rd_hold_en", 32'(read_enable), 32'd1);
                    cmp("rd_hold_addr", 32'(i_user_data_address), 32'(hr_a));
                end
                hold_w = write_enable && !cmd_ready;
                hold_r = read_enable && !cmd_ready;
                hw_a = i_user_data_address; hw_d = i_user_data; hr_a = i_user_data_address;
                if (out_cur > max_out) max_out = out_cur;
                if (write_enable && cmd_ready) begin
                    if (exp_wr.size() == 0) cmp("wr_extra", 32'd1, 32'd0);
                    else begin
                        wr_t e;
                        e = exp_wr.pop_front();
                        cmp("wr_addr", 32'(i_user_data_address), 32'(e.a));
                        cmp("wr_data", 32'(i_user_data), 32'(e.d));
                    end
                end
                if (read_enable) begin
                    cmp("rd_limit", 32'(out_cur < 4), 32'd1);
                    if (cmd_ready) begin
                        if (exp_rd.size() == 0) cmp("rd_extra", 32'd1, 32'd0);
                        else cmp("rd_addr", 32'(i_user_data_address), 32'(exp_rd.pop_front()));
                    end
                end
                if (done && !done_q) begin
                    if (exp_res.size() == 0) cmp("done_extra", 32'd1, 32'd0);
                    else begin
                        res_t r;
                        r = exp_res.pop_front();
                        cmp("res_error_count", 32'(error_count), 32'(r.ec));
                        cmp("res_pass", 32'(pass), 32'(r.p));
                        cmp("res_busy", 32'(busy), 32'd0);
                        if (r.ec != 16'd0) begin
                            cmp("res_first_addr", 32'(first_error_address), 32'(r.fa));
                            cmp("res_first_data", 32'(first_error_data), 32'(r.fd));
                        end
                        cmp("res_writes_left", 32'(exp_wr.size()), 32'd0);
                        cmp("res_reads_left", 32'(exp_rd.size()), 32'd0);
                        cmp("res_returns", 32'(rd_returned), 32'd256);
                        cmp("res_done_latency", 32'(cyc), 32'(last_ret_cyc + 1));
                    end
                end
                done_q = done;
            end
        end
    end

    // Expected pattern, worked out from the pattern definitions
    function automatic logic [15:0] exp_pat(input int m, input int k, input logic [15:0] lf);
        case (m)
            0: return 16'(k);
            1: return ~16'(k);
            2: return 16'd1 << (k % 16);
            default: return lf;
        endcase
    endfunction

    task automatic run(input int m, input bit inj, input logic [15:0] ec, input bit p,
                       input logic [17:0] fa, input logic [15:0] fd, input bit wait_done);
        logic [15:0] lf;
        int n;
        lf = 16'hACE1;
        for (int k = 0; k < 256; k++) begin
            logic [15:0] d;
            d = exp_pat(m, k, lf);
            if (inj && k == 0) d = d ^ 16'h0001;
            exp_wr.push_back('{18'(k), d});
            exp_rd.push_back(18'(k));
            lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
        end
        exp_res.push_back('{ec, p, fa, fd});
        rd_returned = 0;
        rd_accepted = 0;
        @(negedge clk); #2;
        start = 1'b1;
        mode = 2'(m);
`ifdef ERROR_INJECT_EN
        inject_error = inj;
`endif
        @(negedge clk); #2;
        start = 1'b0;
        cmp("start_latency_we", 32'(write_enable), 32'd1);
        cmp("start_busy", 32'(busy), 32'd1);
        cmp("start_clears_errors", 32'(error_count), 32'd0);
        if (wait_done) begin
            n = 0;
            while (!done && n < 20000) begin @(negedge clk); n++; end
            if (!done) begin
                cmp("run_timeout", 32'd0, 32'd1);
                exp_wr.delete(); exp_rd.delete(); exp_res.delete();
            end
            @(negedge clk); #2;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
`ifdef ERROR_INJECT_EN
        inject_error = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #2;
        cmp("rst_busy", 32'(busy), 32'd0);
        cmp("rst_done", 32'(done), 32'd0);
        cmp("rst_we", 32'(write_enable), 32'd0);
        cmp("rst_re", 32'(read_enable), 32'd0);
        cmp("rst_error_count", 32'(error_count), 32'd0);
        reset = 1'b0;

        // Stray return in IDLE is one error, cleared by the next start
        @(negedge clk); #2;
        spur_req = 1;
        repeat (3) @(negedge clk);
        #2;
        cmp("spurious_error_count", 32'(error_count), 32'd1);
        cmp("spurious_done", 32'(done), 32'd0);

        // Ideal memory, incrementing pattern
        lat = 3; stall = 0;
        run(0, 0, 16'd0, 1'b1, 18'd0, 16'd0, 1);

        // Walking one with cmd_ready toggling
        stall = 1;
        run(2, 0, 16'd0, 1'b1, 18'd0, 16'd0, 1);
        cmp("walk_one_index17", 32'(mem[18'd17]), 32'h0002);
        stall = 0;

        // Long read latency exercises the outstanding limit
        lat = 20; max_out = 0;
        run(1, 0, 16'd0, 1'b1, 18'd0, 16'd0, 1);
        cmp("max_outstanding", 32'(max_out), 32'd4);
        lat = 3;

        // Corrupted readback at addresses 5 and 9
        corrupt = 1;
        run(0, 0, 16'd2, 1'b0, 18'd5, 16'h0000, 1);
        corrupt = 0;

        // LFSR pattern
        run(3, 0, 16'd0, 1'b1, 18'd0, 16'd0, 1);

        // Reset in the middle of the read phase
        run(0, 0, 16'd0, 1'b1, 18'd0, 16'd0, 0);
        begin
            int n;
            n = 0;
            while (rd_accepted < 50 && n < 5000) begin @(negedge clk); n++; end
            cmp("reached_read_phase", 32'(rd_accepted >= 50), 32'd1);
        end
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        cmp("midrst_outputs",
            32'({write_enable, read_enable, busy, done, pass} | 5'(error_count != 0)
                | 5'(i_user_data_address != 0) | 5'(i_user_data != 0)), 32'd0);
        exp_wr.delete(); exp_rd.delete(); exp_res.delete();
        rq.delete(); out_m = 0; out_cur = 0;
        @(negedge clk); #2;
        reset = 1'b0;
        run(0, 0, 16'd0, 1'b1, 18'd0, 16'd0, 1);

`ifdef ERROR_INJECT_EN
        run(0, 1, 16'd1, 1'b0, 18'd0, 16'h0001, 1);
        inject_error = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
